// File: rtl/subpel_sched_pkg.sv
// ============================================================================
// Module : subpel_sched_pkg
// Brief  : Shared types, window geometry and arbitration helper for the
//          subpixel window scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package subpel_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WIN_ROWS = 15;
  localparam int PIX_BITS = 8;
  localparam int ROW_BITS = 120;
  localparam int WIN_BITS = 1800;

  // Candidate index for the step-th position of a rotating search after last.
  function automatic int rr_pick_index(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/subpel_req_arbiter.sv
// ============================================================================
// Module : subpel_req_arbiter
// Brief  : Picks one requester. SUBPEL_RR_ARB_EN selects round-robin starting
//          after the last owner; otherwise lowest asserted index wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module subpel_req_arbiter
  import subpel_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
`ifdef SUBPEL_RR_ARB_EN
  input  logic [IDX_W-1:0]   i_last,
`endif
  output logic [NUM_REQ-1:0] o_win_oh,
  output logic [IDX_W-1:0]   o_win_idx,
  output logic               o_win_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    o_win_any = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SUBPEL_RR_ARB_EN
      w_cand = IDX_W'(rr_pick_index(int'(i_last), k + 1, NUM_REQ));
`else
      w_cand = IDX_W'(k);
`endif
      if (i_en && !o_win_any && i_req[w_cand]) begin
        o_win_any = 1'b1;
        o_win_idx = w_cand;
      end
    end
    if (o_win_any) begin
      o_win_oh = NUM_REQ'(1) << o_win_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/subpel_window_scheduler.sv
// ============================================================================
// Module : subpel_window_scheduler
// Brief  : Shares one subpixel interpolator among NUM_REQ requesters: fetches
//          the 15x15 window, runs the interpolator, pulses done to the owner.
//          Build option SUBPEL_RR_ARB_EN selects round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module subpel_window_scheduler
  import subpel_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_W        = 20,
  parameter int ROW_STRIDE    = 15,
  parameter int INTERP_CYCLES = 52
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_busy,
  output logic                      o_rd_req_valid,
  output logic [ADDR_W-1:0]         o_rd_req_addr,
  input  logic                      i_rd_req_ready,
  input  logic                      i_rd_data_valid,
  input  logic [ROW_BITS-1:0]       i_rd_data,
  output logic                      o_interp_rst,
  output logic [WIN_BITS-1:0]       o_in_buffer
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CYC_W = $clog2(INTERP_CYCLES + 1);
  localparam int ROW_W = $clog2(WIN_ROWS + 1);
  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(WIN_ROWS - 1);
  localparam logic [ADDR_W-1:0]  STRIDE   = ADDR_W'(ROW_STRIDE);
  localparam logic [CYC_W-1:0]   CYC_LAST = CYC_W'(INTERP_CYCLES);

  state_t                r_state;
  logic [IDX_W-1:0]      r_owner;
  logic                  r_arb_en;
  logic [ROW_W-1:0]      r_req_row;
  logic [ROW_W-1:0]      r_rsp_row;
  logic [CYC_W-1:0]      r_cyc;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_busy;
  logic                  r_rd_req_valid;
  logic [ADDR_W-1:0]     r_rd_req_addr;
  logic                  r_interp_rst;
  logic [WIN_BITS-1:0]   r_in_buffer;
`ifdef SUBPEL_RR_ARB_EN
  logic [IDX_W-1:0]      r_last;
`endif

  logic [NUM_REQ-1:0]    w_win_oh;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_win_any;
  logic                  w_arb_en;
  logic [ADDR_W-1:0]     w_win_base;

  // Grant is decided combinationally in IDLE so the FETCH state follows the grant cycle directly.
  assign w_arb_en = r_arb_en && (r_state == IDLE);

  subpel_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req     (i_req),
    .i_en      (w_arb_en),
`ifdef SUBPEL_RR_ARB_EN
    .i_last    (r_last),
`endif
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_win_any (w_win_any)
  );

  always_comb begin
    w_win_base = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == IDX_W'(i)) begin
        w_win_base = i_req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_owner        <= '0;
      r_arb_en       <= 1'b0;
      r_req_row      <= '0;
      r_rsp_row      <= '0;
      r_cyc          <= '0;
      r_done         <= '0;
      r_busy         <= 1'b0;
      r_rd_req_valid <= 1'b0;
      r_rd_req_addr  <= '0;
      r_interp_rst   <= 1'b0;
      r_in_buffer    <= '0;
`ifdef SUBPEL_RR_ARB_EN
      r_last         <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_any) begin
            r_owner        <= w_win_idx;
            r_arb_en       <= 1'b0;
            r_busy         <= 1'b1;
            r_rd_req_valid <= 1'b1;
            r_rd_req_addr  <= w_win_base;
            r_req_row      <= '0;
            r_rsp_row      <= '0;
            r_state        <= FETCH;
`ifdef SUBPEL_RR_ARB_EN
            r_last         <= w_win_idx;
`endif
          end else begin
            r_arb_en <= 1'b1;
          end
        end
        FETCH: begin
          // Issue and return sides advance independently.
          if (r_rd_req_valid && i_rd_req_ready) begin
            if (r_req_row == LAST_ROW) begin
              r_rd_req_valid <= 1'b0;
            end else begin
              r_req_row     <= r_req_row + ROW_W'(1);
              r_rd_req_addr <= r_rd_req_addr + STRIDE;
            end
          end
          if (i_rd_data_valid) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
              if (r_rsp_row == ROW_W'(r)) begin
                r_in_buffer[r*ROW_BITS +: ROW_BITS] <= i_rd_data;
              end
            end
            r_rsp_row <= r_rsp_row + ROW_W'(1);
            if (r_rsp_row == LAST_ROW) begin
              r_state      <= RUN;
              r_interp_rst <= 1'b1;
              r_cyc        <= CYC_W'(1);
            end
          end
        end
        RUN: begin
          if (r_cyc == CYC_LAST) begin
            r_state <= DONE;
            r_done  <= NUM_REQ'(1) << r_owner;
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        DONE: begin
          r_interp_rst <= 1'b0;
          r_busy       <= 1'b0;
          r_arb_en     <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt          = w_win_oh;
  assign o_done         = r_done;
  assign o_busy         = r_busy | w_win_any;
  assign o_rd_req_valid = r_rd_req_valid;
  assign o_rd_req_addr  = r_rd_req_addr;
  assign o_interp_rst   = r_interp_rst;
  assign o_in_buffer    = r_in_buffer;

endmodule

`default_nettype wire

// File: tb/tb_subpel_window_scheduler.sv
// ============================================================================
// Module : tb_subpel_window_scheduler
// Brief  : Directed self-checking bench for subpel_window_scheduler with a
//          small in-order reference-memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_subpel_window_scheduler;

  localparam int NR     = 4;
  localparam int AW     = 20;
  localparam int STRIDE = 15;
  localparam int IC     = 52;
`ifdef SUBPEL_RR_ARB_EN
  localparam int NJOBS  = 5;
`else
  localparam int NJOBS  = 3;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req, req_nx;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   gnt, done;
  logic            busy, rvalid, rready, dvalid, irst;
  logic [AW-1:0]   raddr;
  logic [119:0]    rdata;
  logic [1799:0]   inbuf;

  always #5 clk = ~clk;

  subpel_window_scheduler #(
    .NUM_REQ(NR), .ADDR_W(AW), .ROW_STRIDE(STRIDE), .INTERP_CYCLES(IC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req           (req),
    .i_req_addr      (req_addr),
    .o_gnt           (gnt),
    .o_done          (done),
    .o_busy          (busy),
    .o_rd_req_valid  (rvalid),
    .o_rd_req_addr   (raddr),
    .i_rd_req_ready  (rready),
    .i_rd_data_valid (dvalid),
    .i_rd_data       (rdata),
    .o_interp_rst    (irst),
    .o_in_buffer     (inbuf)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  logic [AW-1:0] mem_a[$];
  int            mem_due[$];
  logic [AW-1:0] acc_q[$];
  int  lat = 1;
  bit  toggle = 0;
  bit  spur_tail = 0;
  int  spur_cyc = -1;
  int  ret_cnt, last_ret_cyc, irst_cyc, gnt_cyc, done_cyc;
  logic [NR-1:0] gnt_val, done_val;
  bit  p_valid = 0, p_ready = 0, p_irst = 0;
  logic [AW-1:0] p_addr = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] pat(input logic [AW-1:0] a);
    logic [119:0] r;
    for (int c = 0; c < 15; c++) r[8*c +: 8] = 8'(a[7:0] * 3 + c * 17 + a[15:8]);
    return r;
  endfunction

  task automatic clr();
    acc_q.delete();
    ret_cnt = 0; last_ret_cyc = -1; irst_cyc = -1; gnt_cyc = -1; done_cyc = -1;
    gnt_val = '0; done_val = '0;
  endtask

  // One clock: drive at negedge, sample 1 ns later.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    req    = req_nx;
    rready = toggle ? (cyc_n % 2 == 0) : 1'b1;
    dvalid = 1'b0;
    rdata  = '0;
    if (mem_a.size() > 0 && mem_due[0] <= cyc_n) begin
      dvalid = 1'b1;
      rdata  = pat(mem_a.pop_front());
      void'(mem_due.pop_front());
      ret_cnt++;
      last_ret_cyc = cyc_n;
      if (ret_cnt == 15 && spur_tail) spur_cyc = cyc_n + 1;
    end else if (cyc_n == spur_cyc) begin
      dvalid = 1'b1;
      rdata  = {15{8'hA5}};
    end
    #1;
    if (gnt != '0) begin gnt_val = gnt; gnt_cyc = cyc_n; end
    if (p_valid && !p_ready) begin
      chk("addr_hold_valid", rvalid, 1);
      chk("addr_hold", raddr, p_addr);
    end
    if (rvalid && rready) begin
      acc_q.push_back(raddr);
      mem_a.push_back(raddr);
      mem_due.push_back(cyc_n + lat);
    end
    if (irst && !p_irst) irst_cyc = cyc_n;
    if (done != '0) begin done_val = done; done_cyc = cyc_n; end
    p_valid = rvalid; p_ready = rready; p_irst = irst; p_addr = raddr;
  endtask

  task automatic wait_gnt(input int budget);
    for (int k = 0; k < budget && gnt_val == '0; k++) cyc();
    chk("gnt_timeout", gnt_val != '0, 1);
    chk("busy_at_gnt", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_val == '0; k++) cyc();
    chk("done_timeout", done_val != '0, 1);
  endtask

  task automatic check_buf(input logic [AW-1:0] base);
    for (int r = 0; r < 15; r++)
      chk($sformatf("in_buffer_row%0d", r), inbuf[120*r +: 120], pat(AW'(base + r * STRIDE)));
  endtask

  task automatic check_job(input logic [AW-1:0] base, input logic [NR-1:0] oh);
    chk("gnt_owner", gnt_val, oh);
    chk("done_owner", done_val, oh);
    chk("rows_issued", acc_q.size(), 15);
    for (int r = 0; r < 15; r++)
      chk($sformatf("rd_addr_row%0d", r), (r < acc_q.size()) ? acc_q[r] : 'x, AW'(base + r * STRIDE));
    chk("irst_after_row14", irst_cyc, last_ret_cyc + 1);
    chk("run_length", done_cyc - irst_cyc, IC);
    check_buf(base);
  endtask

  initial begin
    int prev_done;
    req = '0; req_nx = '0; req_addr = '0; rready = 1'b1; dvalid = 1'b0; rdata = '0;
    clr();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_irst", irst, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_inbuf", inbuf == '0, 1);
    rst_n = 1'b1;
    cyc(); cyc();

    // Single job, always ready, 1-cycle return.
    clr();
    req_addr[0*AW +: AW] = 20'h00100;
    req_nx = 4'b0001;
    wait_gnt(5);
    req_nx = '0;
    wait_done(200);
    check_job(20'h00100, 4'b0001);
    chk("min_latency", done_cyc - gnt_cyc, 69);
    chk("irst_in_done", irst, 1);
    cyc();
    chk("busy_after_done", busy, 0);
    chk("irst_after_done", irst, 0);
    chk("done_one_cycle", done, 0);

    // Spurious return while IDLE.
    spur_cyc = cyc_n + 1;
    cyc(); cyc();
    check_buf(20'h00100);

    // Backpressure with 3-cycle returns.
    clr();
    toggle = 1; lat = 3;
    req_addr[1*AW +: AW] = 20'h02000;
    req_nx = 4'b0010;
    wait_gnt(5);
    req_nx = '0;
    wait_done(400);
    check_job(20'h02000, 4'b0010);
    toggle = 0; lat = 1;
    cyc();

    // Address wrap plus a stray return right after row 14 (lands in RUN).
    clr();
    spur_tail = 1;
    req_addr[2*AW +: AW] = 20'hFFFF0;
    req_nx = 4'b0100;
    wait_gnt(5);
    req_nx = '0;
    wait_done(200);
    spur_tail = 0;
    check_job(20'hFFFF0, 4'b0100);
    chk("wrap_row2", (acc_q.size() > 2) ? acc_q[2] : 'x, 20'h0000E);
    cyc();

    // Async reset in RUN cycle 20.
    clr();
    req_addr[3*AW +: AW] = 20'h00300;
    req_nx = 4'b1000;
    wait_gnt(5);
    req_nx = '0;
    for (int k = 0; k < 100 && irst_cyc < 0; k++) cyc();
    chk("run_reached", irst_cyc >= 0, 1);
    repeat (19) cyc();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_irst", irst, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_irst", irst, 0);
    chk("arst_raddr", raddr, 0);
    chk("arst_inbuf", inbuf == '0, 1);
    mem_a.delete(); mem_due.delete();
    p_valid = 0; p_irst = 0;
    cyc();
    rst_n = 1'b1;
    clr();
    repeat (80) cyc();
    chk("no_done_after_rst", done_val, 0);
    clr();
    req_nx = 4'b1000;
    wait_gnt(5);
    req_nx = '0;
    wait_done(200);
    check_job(20'h00300, 4'b1000);
    cyc();

    // Arbitration with all requests held.
    req_addr[0*AW +: AW] = 20'h01000;
    req_addr[1*AW +: AW] = 20'h01100;
    req_addr[2*AW +: AW] = 20'h01200;
    req_addr[3*AW +: AW] = 20'h01300;
    req_nx = 4'b1111;
    prev_done = -1;
    for (int j = 0; j < NJOBS; j++) begin
      clr();
      wait_gnt(5);
      if (j == NJOBS - 1) req_nx = '0;
`ifdef SUBPEL_RR_ARB_EN
      chk($sformatf("arb_job%0d", j), gnt_val, 4'b0001 << (j % NR));
`else
      chk($sformatf("arb_job%0d", j), gnt_val, 4'b0001);
`endif
      if (prev_done >= 0) chk("gnt_after_done", gnt_cyc, prev_done + 1);
      wait_done(200);
      chk("arb_done_owner", done_val, gnt_val);
      prev_done = done_cyc;
    end
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
